uart_apb_sequencer: RTL and testbench

APB master that sequences all register and data accesses to the UART APB slave (transfer/PENABLE/PWRITE/PADDR/PWDATA → PREADY/PRDATA).
Shares the single APB port between two requesters: req0 carries configuration and status traffic, req1 carries the TX/RX data stream. Arbitration is round-robin.
Drives the APB SETUP/ACCESS phases and waits on PREADY with a timeout. Returns read data or an error to the requester that was granted.

---
 rtl/uart_apb_pkg.sv | 32 +++
 rtl/uart_apb_sequencer_rr_arb2.sv | 39 +++
 rtl/uart_apb_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB sequencer.
//   seq_state_t   : APB master phase (IDLE -> SETUP -> ACCESS -> IDLE)
//   UART_OFF_*    : register offsets of the UART APB slave
//   rr_pick()     : 2-way round-robin winner for a request vector and
//                   a priority pointer
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } seq_state_t;

  localparam logic [7:0] UART_OFF_CTRL  = 8'h00;
  localparam logic [7:0] UART_OFF_STATE = 8'h04;
  localparam logic [7:0] UART_OFF_CD    = 8'h08;
  localparam logic [7:0] UART_OFF_DATA  = 8'h0C;

  // Winner id: the only requester when just one is pending, otherwise the
  // one the pointer favours. Returns 0 when nothing is requested.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    logic id;
    case (req)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ptr;
      default: id = 1'b0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/uart_apb_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : pending requests (bit 0 = requester 0)
//   advance    : the current owner's transfer has finished
//   owner      : id of the requester whose transfer finished
//   grant[1:0] : one-hot winner (all zero when nothing requested)
//   gid        : index of the winner
module rr_arb2
  import uart_apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] grant,
  output logic       gid
);

  // Pointer names the requester that wins a tie; 0 after reset.
  logic ptr_q;
  logic ptr_d;

  // After a completed transfer the other requester gets priority, so a
  // tie always goes to the one not granted last.
  assign ptr_d = advance ? ~owner : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gid   = rr_pick(req, ptr_q);
  assign grant = (req == 2'b00) ? 2'b00 : (gid ? 2'b10 : 2'b01);

endmodule

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that shares one APB port between a
// configuration/status requester (r0) and a data-stream requester (r1).
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   rN_valid/ready         : request handshake (ready is a 1-cycle pulse)
//   rN_write/addr/wdata    : request fields, latched on ready
//   rN_rvalid/rdata/err    : completion pulse, captured PRDATA, timeout flag
//   transfer/PENABLE/...   : APB master outputs
//   PREADY/PRDATA          : APB slave response
//   busy                   : a transfer is in progress
//   grant_id               : requester owning the bus
module uart_apb_sequencer
  import uart_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_write,
  input  logic [7:0]  r0_addr,
  input  logic [7:0]  r0_wdata,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_write,
  input  logic [7:0]  r1_addr,
  input  logic [7:0]  r1_wdata,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        transfer,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [7:0]  PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t      state_q;
  logic            transfer_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [7:0]      paddr_q;
  logic [7:0]      pwdata_q;
  logic            gid_q;
  logic            r0_ready_q;
  logic            r1_ready_q;
  logic            r0_rvalid_q;
  logic            r1_rvalid_q;
  logic [31:0]     r0_rdata_q;
  logic [31:0]     r1_rdata_q;
  logic            r0_err_q;
  logic            r1_err_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  logic [1:0]      arb_grant;
  logic            arb_gid;
  logic            timeout_hit;
  logic            done;

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_q == TO_LAST);
  // A transfer ends on PREADY or on the last permitted ACCESS cycle.
  assign done        = (state_q == ACCESS) && (PREADY || timeout_hit);

  rr_arb2 u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     ({r1_valid, r0_valid}),
    .advance (done),
    .owner   (gid_q),
    .grant   (arb_grant),
    .gid     (arb_gid)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      transfer_q  <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      gid_q       <= 1'b0;
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= 32'h0;
      r1_rdata_q  <= 32'h0;
      r0_err_q    <= 1'b0;
      r1_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // PREADY is deliberately not looked at here: the slave repeats
          // it for one stale cycle after the previous transfer.
          if (arb_grant != 2'b00) begin
            pwrite_q   <= arb_gid ? r1_write : r0_write;
            paddr_q    <= arb_gid ? r1_addr  : r0_addr;
            pwdata_q   <= arb_gid ? r1_wdata : r0_wdata;
            gid_q      <= arb_gid;
            r0_ready_q <= arb_grant[0];
            r1_ready_q <= arb_grant[1];
            transfer_q <= 1'b1;
            penable_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            // PREADY wins over a simultaneous timeout.
            if (gid_q) begin
              r1_rdata_q  <= PRDATA;
              r1_err_q    <= 1'b0;
              r1_rvalid_q <= 1'b1;
            end else begin
              r0_rdata_q  <= PRDATA;
              r0_err_q    <= 1'b0;
              r0_rvalid_q <= 1'b1;
            end
            transfer_q <= 1'b0;
            penable_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else if (timeout_hit) begin
            if (gid_q) begin
              r1_rdata_q  <= 32'h0;
              r1_err_q    <= 1'b1;
              r1_rvalid_q <= 1'b1;
            end else begin
              r0_rdata_q  <= 32'h0;
              r0_err_q    <= 1'b1;
              r0_rvalid_q <= 1'b1;
            end
            transfer_q <= 1'b0;
            penable_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          transfer_q <= 1'b0;
          penable_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign r0_err    = r0_err_q;
  assign r1_err    = r1_err_q;
  assign transfer  = transfer_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Self-checking bench for uart_apb_sequencer with a small registered
// APB slave model and a scoreboard of expected completions.
module tb_uart_apb_sequencer;
  import uart_apb_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_write, r0_rvalid, r0_err;
  logic [7:0]  r0_addr, r0_wdata;
  logic [31:0] r0_rdata;
  logic        r1_valid, r1_ready, r1_write, r1_rvalid, r1_err;
  logic [7:0]  r1_addr, r1_wdata;
  logic [31:0] r1_rdata;
  logic        transfer, penable, pwrite, pready, busy, grant_id;
  logic [7:0]  paddr, pwdata;
  logic [31:0] prdata;

  int vectors = 0;
  int miscompares = 0;
  int cycle_no = 0;
  int r0_rv_cnt = 0;
  int r1_rv_cnt = 0;

  typedef struct {
    logic        gid;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Slave model: PREADY is registered and goes high in ACCESS cycle
  // wait_n (wait_n == 0 means never); optionally repeats it one cycle.
  int wait_n = 2;
  bit stale_en = 1;
  int acc_cnt;

  uart_apb_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .PCLK(clk), .PRESETn(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .transfer(transfer), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  always @(negedge clk) begin
    if (r0_rvalid) r0_rv_cnt <= r0_rv_cnt + 1;
    if (r1_rvalid) r1_rv_cnt <= r1_rv_cnt + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready  <= 1'b0;
      acc_cnt <= 0;
    end else if (transfer && penable) begin
      if (pready) begin
        pready  <= stale_en;
        acc_cnt <= 0;
      end else begin
        acc_cnt <= acc_cnt + 1;
        pready  <= (wait_n != 0) && (acc_cnt + 2 == wait_n);
      end
    end else begin
      pready  <= 1'b0;
      acc_cnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst_n = 1'b0;
    r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for either ready pulse; reports id and cycles taken.
  task automatic wait_ready(output logic id, output int cyc, output bit ok);
    id = 0; cyc = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (r0_ready || r1_ready) begin
        id = r1_ready;
        ok = 1;
        break;
      end
    end
  endtask

  // Waits (bounded) for the given requester's rvalid, watching PADDR.
  task automatic wait_rvalid(input logic id, input logic [7:0] exp_addr,
                             output int cyc, output int acc, output bit addr_ok,
                             output bit ok);
    cyc = 0; acc = 0; addr_ok = 1; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (penable) acc++;
      if (transfer && paddr !== exp_addr) addr_ok = 0;
      if (id ? r1_rvalid : r0_rvalid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({transfer, penable, pwrite, paddr, pwdata, busy, grant_id} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %b/%b/%b/%h/%h/%b/%b, required all 0",
               transfer, penable, pwrite, paddr, pwdata, busy, grant_id);
    end
    vectors++;
    if ({r0_ready, r0_rvalid, r0_err, r0_rdata, r1_ready, r1_rvalid, r1_err, r1_rdata} !== 70'h0) begin
      miscompares++;
      $display("FAIL reset_req: got r0 %h/%b r1 %h/%b, required all 0",
               r0_rdata, r0_err, r1_rdata, r1_err);
    end
    $display("reset: outputs checked");
  endtask

  // Scoreboard pop and compare against what the DUT reported.
  task automatic test_write_r0;
    logic id; int cyc, acc; bit ok, aok;
    exp_t e;
    wait_n = 2; prdata = 32'h0000_00A5;
    sb.push_back('{gid: 1'b0, err: 1'b0, rdata: 32'h0000_00A5});
    r0_write = 1; r0_addr = UART_OFF_CD; r0_wdata = 8'h00; r0_valid = 1;
    wait_ready(id, cyc, ok);
    r0_valid = 0;
    vectors++;
    if (!ok || id !== 1'b0 || cyc != 1) begin
      miscompares++;
      $display("FAIL wr_ready: got ok=%0d id=%0d cyc=%0d, required ok=1 id=0 cyc=1", ok, id, cyc);
    end
    vectors++;
    if (transfer !== 1 || penable !== 0 || pwrite !== 1 || paddr !== 8'h08 || grant_id !== 0) begin
      miscompares++;
      $display("FAIL wr_setup: got t=%b en=%b w=%b a=%h g=%b, required 1 0 1 08 0",
               transfer, penable, pwrite, paddr, grant_id);
    end
    wait_rvalid(1'b0, 8'h08, cyc, acc, aok, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || cyc != 3 || acc != 2 || !aok) begin
      miscompares++;
      $display("FAIL wr_latency: got ok=%0d cyc=%0d acc=%0d addr_ok=%0d, required 1 3 2 1", ok, cyc, acc, aok);
    end
    vectors++;
    if (r0_rdata !== e.rdata || r0_err !== e.err) begin
      miscompares++;
      $display("FAIL wr_result: got %h/%b, required %h/%b", r0_rdata, r0_err, e.rdata, e.err);
    end
    $display("write r0 addr=08: rdata=%h err=%b cyc=%0d", r0_rdata, r0_err, cyc);
  endtask

  task automatic test_read_r0;
    logic id; int cyc, acc; bit ok, aok;
    logic [31:0] r1d; logic r1e; int r1c;
    exp_t e;
    r1d = r1_rdata; r1e = r1_err; r1c = r1_rv_cnt;
    @(posedge clk); #1;
    wait_n = 2; prdata = 32'h0000_0005;
    sb.push_back('{gid: 1'b0, err: 1'b0, rdata: 32'h0000_0005});
    r0_write = 0; r0_addr = UART_OFF_CTRL; r0_valid = 1;
    wait_ready(id, cyc, ok);
    r0_valid = 0;
    wait_rvalid(1'b0, 8'h00, cyc, acc, aok, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || r0_rdata !== e.rdata || r0_err !== e.err || pwrite !== 0) begin
      miscompares++;
      $display("FAIL rd_result: got ok=%0d %h/%b w=%b, required 1 %h/%b w=0",
               ok, r0_rdata, r0_err, pwrite, e.rdata, e.err);
    end
    @(posedge clk); #1;
    vectors++;
    if (r1_rdata !== r1d || r1_err !== r1e || r1_rv_cnt != r1c) begin
      miscompares++;
      $display("FAIL rd_r1_untouched: got %h/%b/%0d, required %h/%b/%0d",
               r1_rdata, r1_err, r1_rv_cnt, r1d, r1e, r1c);
    end
    $display("read r0 addr=00: rdata=%h err=%b", r0_rdata, r0_err);
  endtask

  task automatic test_back_to_back;
    logic id; int cyc, acc; bit ok, aok;
    int last_ready, r0c, r1c;
    exp_t e;
    do_reset();
    wait_n = 2; stale_en = 1; prdata = 32'hB0;
    r0c = r0_rv_cnt; r1c = r1_rv_cnt;
    for (int i = 0; i < 4; i++)
      sb.push_back('{gid: i[0], err: 1'b0, rdata: 32'hB0 + i});
    r0_write = 0; r0_addr = UART_OFF_STATE; r0_valid = 1;
    r1_write = 1; r1_addr = UART_OFF_DATA;  r1_wdata = 8'h55; r1_valid = 1;
    last_ready = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ready(id, cyc, ok);
      if (i == 3) begin
        r0_valid = 0; r1_valid = 0;
      end
      e = sb.pop_front();
      vectors++;
      if (!ok || id !== e.gid || grant_id !== e.gid) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got ok=%0d id=%0d gid=%b, required id=%0d", i, ok, id, grant_id, e.gid);
      end
      if (i > 0) begin
        vectors++;
        if (cycle_no - last_ready != 4) begin
          miscompares++;
          $display("FAIL rr_gap%0d: got %0d cycles ready-to-ready, required 4", i, cycle_no - last_ready);
        end
      end
      last_ready = cycle_no;
      wait_rvalid(id, id ? 8'h0C : 8'h04, cyc, acc, aok, ok);
      vectors++;
      if (!ok || cyc != 3 || !aok || busy !== 0 ||
          (id ? r1_rdata : r0_rdata) !== e.rdata) begin
        miscompares++;
        $display("FAIL rr_done%0d: got ok=%0d cyc=%0d aok=%0d busy=%b rdata=%h, required 1 3 1 0 %h",
                 i, ok, cyc, aok, busy, id ? r1_rdata : r0_rdata, e.rdata);
      end
      $display("rr xfer %0d: gid=%0d rdata=%h", i, id, id ? r1_rdata : r0_rdata);
      prdata = 32'hB0 + i + 1;
    end
    repeat (6) @(posedge clk); #1;
    vectors++;
    if (r0_rv_cnt - r0c != 2 || r1_rv_cnt - r1c != 2 || busy !== 0) begin
      miscompares++;
      $display("FAIL rr_count: got r0=%0d r1=%0d busy=%b, required 2 2 0",
               r0_rv_cnt - r0c, r1_rv_cnt - r1c, busy);
    end
  endtask

  task automatic test_timeout;
    logic id; int cyc, acc; bit ok, aok;
    exp_t e;
    wait_n = 0; prdata = 32'hDEAD_BEEF;
    sb.push_back('{gid: 1'b1, err: 1'b1, rdata: 32'h0});
    r1_write = 1; r1_addr = UART_OFF_DATA; r1_wdata = 8'h3C; r1_valid = 1;
    wait_ready(id, cyc, ok);
    r1_valid = 0;
    wait_rvalid(1'b1, 8'h0C, cyc, acc, aok, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || acc != TO || cyc != TO + 1) begin
      miscompares++;
      $display("FAIL to_cycles: got ok=%0d access=%0d cyc=%0d, required 1 %0d %0d", ok, acc, cyc, TO, TO + 1);
    end
    vectors++;
    if (r1_err !== e.err || r1_rdata !== e.rdata || transfer !== 0 || penable !== 0) begin
      miscompares++;
      $display("FAIL to_result: got err=%b rdata=%h t=%b en=%b, required %b %h 0 0",
               r1_err, r1_rdata, transfer, penable, e.err, e.rdata);
    end
    $display("timeout r1: err=%b rdata=%h access=%0d", r1_err, r1_rdata, acc);
  endtask

  task automatic test_ready_at_timeout;
    logic id; int cyc, acc; bit ok, aok;
    exp_t e;
    @(posedge clk); #1;
    wait_n = TO; prdata = 32'h1234_5678;
    sb.push_back('{gid: 1'b0, err: 1'b0, rdata: 32'h1234_5678});
    r0_write = 0; r0_addr = UART_OFF_STATE; r0_valid = 1;
    wait_ready(id, cyc, ok);
    r0_valid = 0;
    wait_rvalid(1'b0, 8'h04, cyc, acc, aok, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || acc != TO || r0_err !== e.err || r0_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL edge_timeout: got ok=%0d access=%0d err=%b rdata=%h, required 1 %0d %b %h",
               ok, acc, r0_err, r0_rdata, TO, e.err, e.rdata);
    end
    $display("ready at timeout r0: err=%b rdata=%h", r0_err, r0_rdata);
  endtask

  task automatic test_reset_mid;
    logic id; int cyc, acc; bit ok, aok;
    int r0c, r1c;
    exp_t e;
    @(posedge clk); #1;
    wait_n = 0; prdata = 32'h0;
    r0_write = 1; r0_addr = UART_OFF_CD; r0_wdata = 8'h11; r0_valid = 1;
    wait_ready(id, cyc, ok);
    r0_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    r0c = r0_rv_cnt; r1c = r1_rv_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (transfer !== 0 || penable !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL async_reset: got t=%b en=%b busy=%b, required 0 0 0", transfer, penable, busy);
    end
    // Tie pending while reset releases.
    wait_n = 2; prdata = 32'h0000_0077;
    r0_write = 0; r0_addr = UART_OFF_CTRL; r0_valid = 1;
    r1_write = 0; r1_addr = UART_OFF_DATA; r1_valid = 1;
    sb.push_back('{gid: 1'b0, err: 1'b0, rdata: 32'h0000_0077});
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_ready(id, cyc, ok);
    r0_valid = 0; r1_valid = 0;
    vectors++;
    if (!ok || id !== 1'b0 || r0_rv_cnt != r0c || r1_rv_cnt != r1c) begin
      miscompares++;
      $display("FAIL post_reset_grant: got ok=%0d id=%0d rv=%0d/%0d, required 1 0 %0d/%0d",
               ok, id, r0_rv_cnt, r1_rv_cnt, r0c, r1c);
    end
    wait_rvalid(1'b0, 8'h00, cyc, acc, aok, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || r0_rdata !== e.rdata || r0_err !== e.err) begin
      miscompares++;
      $display("FAIL post_reset_xfer: got ok=%0d %h/%b, required 1 %h/%b", ok, r0_rdata, r0_err, e.rdata, e.err);
    end
    $display("reset mid-access then tie: gid=%0d rdata=%h", id, r0_rdata);
  endtask

  initial begin
    test_reset();
    test_write_r0();
    test_read_r0();
    test_back_to_back();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
